// File: rtl/average_seq_ctrl.sv
// average_seq_ctrl: sequencer around the pipelined moving-average adder tree.
// Owns the sample history, masks taps beyond the window, tracks tokens and buffers results.
module average_seq_ctrl #(
    parameter int REG_SIZE  = 7,
    parameter int BIT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic [31:0]                          i_cfg_sample_size,
    input  logic                                 i_cfg_update,
    input  logic                                 i_in_valid,
    output logic                                 o_in_ready,
    input  logic [BIT_WIDTH-1:0]                 i_in_data,
    output logic [BIT_WIDTH-1:0]                 o_tree_din,
    output logic [REG_SIZE-1:0][BIT_WIDTH-1:0]   o_tree_prev,
    output logic [31:0]                          o_tree_sample_size,
    input  logic [BIT_WIDTH-1:0]                 i_tree_dout,
    output logic                                 o_out_valid,
    input  logic                                 i_out_ready,
    output logic [BIT_WIDTH-1:0]                 o_out_data,
    output logic                                 o_busy
);

    localparam int PIPE_LAT   = $clog2(REG_SIZE + 1);
    localparam int FIFO_DEPTH = PIPE_LAT + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_FLUSH, S_FILL, S_RUN, S_DRAIN} state_t;

    state_t               r_state;
    logic [BIT_WIDTH-1:0] r_hist [REG_SIZE];
    logic [7:0]           r_fill_cnt;
    logic [31:0]          r_active_n;
    logic [31:0]          r_pend_n;
    logic [PIPE_LAT-1:0]  r_tok_v;
    logic [PIPE_LAT-1:0]  r_tok_e;
    logic [BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic        w_accept;
    logic        w_emit;
    logic        w_push;
    logic        w_pop;
    logic        w_window_done;
    logic [31:0] w_cfg_n;
    logic [31:0] w_inflight;

    // Window sizes the tree cannot represent fall back to 4.
    function automatic logic [31:0] legalise(input logic [31:0] n);
        logic ok;
        ok = (n >= 32'd2) && (n <= 32'd128) && ((n & (n - 32'd1)) == 32'd0)
             && (n <= 32'(REG_SIZE + 1));
        return ok ? n : 32'd4;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            w_inflight = w_inflight + 32'(r_tok_v[i]);
        end
    end

    assign w_cfg_n       = legalise(i_cfg_sample_size);
    assign w_window_done = (32'(r_fill_cnt) == r_active_n - 32'd1);
    assign w_emit        = (r_state == S_RUN) || ((r_state == S_FILL) && w_window_done);
    // Non-emitting tokens are counted too, which keeps the FIFO from ever overflowing.
    assign o_in_ready    = ((r_state == S_FILL) || (r_state == S_RUN))
                           && ((32'(r_count) + w_inflight) < 32'(FIFO_DEPTH))
                           && !i_cfg_update;
    assign w_accept      = i_in_valid && o_in_ready;
    assign w_push        = r_tok_v[PIPE_LAT-1] && r_tok_e[PIPE_LAT-1];
    assign o_out_valid   = (r_count != '0);
    assign w_pop         = o_out_valid && i_out_ready;

    assign o_tree_din         = i_in_data;
    assign o_tree_sample_size = r_active_n;
    assign o_busy             = (r_state == S_DRAIN) || (r_state == S_FLUSH);
    assign o_out_data         = o_out_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        for (int k = 0; k < REG_SIZE; k++) begin
            o_tree_prev[k] = (32'(k) < r_active_n - 32'd1) ? r_hist[k] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= S_FLUSH;
            r_fill_cnt <= '0;
            r_active_n <= w_cfg_n;
            r_pend_n   <= w_cfg_n;
            for (int k = 0; k < REG_SIZE; k++) r_hist[k] <= '0;
        end else begin
            if (i_cfg_update) r_pend_n <= w_cfg_n;
            if (w_accept) begin
                r_hist[0] <= i_in_data;
                for (int k = 1; k < REG_SIZE; k++) r_hist[k] <= r_hist[k-1];
            end
            case (r_state)
                S_FLUSH: begin
                    for (int k = 0; k < REG_SIZE; k++) r_hist[k] <= '0;
                    r_fill_cnt <= '0;
                    r_active_n <= i_cfg_update ? w_cfg_n : r_pend_n;
                    r_state    <= S_FILL;
                end
                S_FILL: begin
                    if (i_cfg_update) begin
                        r_state <= S_DRAIN;
                    end else if (w_accept) begin
                        r_fill_cnt <= r_fill_cnt + 8'd1;
                        if (w_window_done) r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_cfg_update) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_inflight == '0) r_state <= S_FLUSH;
                end
                default: r_state <= S_FLUSH;
            endcase
        end
    end

    // Token at stage i matches the sample that entered the tree i+1 cycles ago.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_tok_v <= '0;
            r_tok_e <= '0;
        end else begin
            r_tok_v[0] <= w_accept;
            r_tok_e[0] <= w_accept && w_emit;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tok_v[i] <= r_tok_v[i-1];
                r_tok_e[i] <= r_tok_e[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_tree_dout;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule
